// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream terminal front end driving the char_mem write port with hardware scroll.
// Optional ATTR_ESC_EN: ESC followed by a byte B makes B the current attribute for PUT and BS writes.
module text_console_writer #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
    input  logic       PIXCLK,
    input  logic       _RST,
    input  logic [7:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       WE,
    output logic [7:0] WX,
    output logic [7:0] WY,
    output logic [7:0] WCHAR,
    output logic [7:0] WATTR,
    output logic [7:0] TOP_ROW,
    output logic [7:0] CURSOR_X,
    output logic [7:0] CURSOR_Y,
    output logic       BUSY
);
`ifdef ATTR_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif
    localparam logic [7:0] LX = 8'(COLS - 1);
    localparam logic [7:0] LY = 8'(ROWS - 1);

    typedef enum logic [1:0] {CLR_ALL, IDLE, PUT, CLR_LINE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d, cy_q, cy_d, top_q, top_d;
    logic [7:0] clr_x_q, clr_x_d, clr_y_q, clr_y_d;
    logic [7:0] px_q, px_d, py_q, py_d, pch_q, pch_d, pat_q, pat_d, attr_q, attr_d;
    logic       put_we_q, put_we_d, scroll_q, scroll_d, esc_q, esc_d;
    logic       nl;
    logic [8:0] row_sum;
    logic [7:0] cur_row;

    assign row_sum = {1'b0, top_q} + {1'b0, cy_q};
    assign cur_row = (row_sum >= 9'(ROWS)) ? 8'(row_sum - 9'(ROWS)) : row_sum[7:0];

    always_ff @(posedge PIXCLK or negedge _RST) begin
        if (!_RST) begin
            state_q  <= CLR_ALL;
            cx_q     <= '0;
            cy_q     <= '0;
            top_q    <= '0;
            clr_x_q  <= '0;
            clr_y_q  <= '0;
            px_q     <= '0;
            py_q     <= '0;
            pch_q    <= 8'h20;
            pat_q    <= DEFAULT_ATTR;
            attr_q   <= DEFAULT_ATTR;
            put_we_q <= 1'b0;
            scroll_q <= 1'b0;
            esc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            top_q    <= top_d;
            clr_x_q  <= clr_x_d;
            clr_y_q  <= clr_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            pch_q    <= pch_d;
            pat_q    <= pat_d;
            attr_q   <= attr_d;
            put_we_q <= put_we_d;
            scroll_q <= scroll_d;
            esc_q    <= esc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        top_d    = top_q;
        clr_x_d  = clr_x_q;
        clr_y_d  = clr_y_q;
        px_d     = px_q;
        py_d     = py_q;
        pch_d    = pch_q;
        pat_d    = pat_q;
        attr_d   = attr_q;
        put_we_d = put_we_q;
        scroll_d = scroll_q;
        esc_d    = esc_q;
        nl       = 1'b0;
        case (state_q)
            CLR_ALL: begin
                cx_d    = '0;
                cy_d    = '0;
                top_d   = '0;
                clr_x_d = (clr_x_q == LX) ? 8'd0 : clr_x_q + 8'd1;
                if (clr_x_q == LX) begin
                    clr_y_d = (clr_y_q == LY) ? 8'd0 : clr_y_q + 8'd1;
                    if (clr_y_q == LY) state_d = IDLE;
                end
            end
            IDLE: begin
                if (DIN_VALID) begin
                    state_d  = PUT;
                    put_we_d = 1'b0;
                    scroll_d = 1'b0;
                    px_d     = cx_q;
                    py_d     = cur_row;
                    pch_d    = DIN;
                    pat_d    = attr_q;
                    if (esc_q) begin
                        attr_d = DIN;
                        esc_d  = 1'b0;
                    end else if (ESC_EN && DIN == 8'h1B) begin
                        esc_d = 1'b1;
                    end else if (DIN >= 8'h20 && DIN <= 8'h7E) begin
                        put_we_d = 1'b1;
                        cx_d     = (cx_q == LX) ? 8'd0 : cx_q + 8'd1;
                        nl       = (cx_q == LX);
                    end else if (DIN == 8'h0A) begin
                        cx_d = '0;
                        nl   = 1'b1;
                    end else if (DIN == 8'h0D) begin
                        cx_d = '0;
                    end else if (DIN == 8'h08 && cx_q != 8'd0) begin
                        cx_d     = cx_q - 8'd1;
                        px_d     = cx_q - 8'd1;
                        pch_d    = 8'h20;
                        put_we_d = 1'b1;
                    end else if (DIN == 8'h0C) begin
                        state_d = CLR_ALL;
                        clr_x_d = '0;
                        clr_y_d = '0;
                        cx_d    = '0;
                        cy_d    = '0;
                        top_d   = '0;
                    end
                    // Scroll: the old top row becomes the new bottom line and is blanked
                    if (nl && cy_q != LY) begin
                        cy_d = cy_q + 8'd1;
                    end else if (nl) begin
                        top_d    = (top_q == LY) ? 8'd0 : top_q + 8'd1;
                        scroll_d = 1'b1;
                        clr_x_d  = '0;
                        clr_y_d  = top_q;
                    end
                end
            end
            PUT: begin
                state_d = scroll_q ? CLR_LINE : IDLE;
            end
            CLR_LINE: begin
                clr_x_d = clr_x_q + 8'd1;
                if (clr_x_q == LX) state_d = IDLE;
            end
            default: state_d = CLR_ALL;
        endcase
    end

    always_comb begin
        DIN_READY = (state_q == IDLE);
        BUSY      = (state_q != IDLE);
        WE        = _RST && ((state_q == CLR_ALL) || (state_q == CLR_LINE) || (state_q == PUT && put_we_q));
        WX        = (state_q == PUT) ? px_q : clr_x_q;
        WY        = (state_q == PUT) ? py_q : clr_y_q;
        WCHAR     = (state_q == PUT) ? pch_q : 8'h20;
        WATTR     = (state_q == PUT) ? pat_q : DEFAULT_ATTR;
        TOP_ROW   = top_q;
        CURSOR_X  = cx_q;
        CURSOR_Y  = cy_q;
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed table plus hand sequences for clear, wrap, scroll and attribute escape.
module tb_text_console_writer;
    logic       PIXCLK = 1'b0;
    logic       _RST = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY, WE, BUSY;
    logic [7:0] WX, WY, WCHAR, WATTR, TOP_ROW, CURSOR_X, CURSOR_Y;

`ifdef ATTR_ESC_EN
    localparam logic [7:0] EA = 8'h1E;
`else
    localparam logic [7:0] EA = 8'h07;
`endif

    text_console_writer dut (
        .PIXCLK(PIXCLK), ._RST(_RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .WE(WE), .WX(WX), .WY(WY), .WCHAR(WCHAR), .WATTR(WATTR), .TOP_ROW(TOP_ROW),
        .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .BUSY(BUSY)
    );

    always #5 PIXCLK = ~PIXCLK;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] din;
        logic       we;
        logic [7:0] wx, wy, wc, cx, cy;
    } vec_t;
    vec_t tv[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 3000 && !DIN_READY; n++) @(negedge PIXCLK);
        if (!DIN_READY) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: DIN_READY stayed low");
        end
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        DIN = b;
        DIN_VALID = 1'b1;
        @(negedge PIXCLK);
        DIN_VALID = 1'b0;
    endtask

    task automatic clear_screen();
        int c;
        send(8'h0C);
        c = int'(WE);
        chk("ff_clear_attr", WATTR, 8'h07);
        for (int n = 0; n < 2500; n++) begin
            @(negedge PIXCLK);
            if (DIN_READY) break;
            if (WE) c++;
        end
        chk("ff_clear_count", c, 2400);
    endtask

    task automatic run_clear_check(input int limit);
        int e = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge PIXCLK);
            if (!WE || WX != 8'(i % 80) || WY != 8'(i / 80) || WCHAR != 8'h20 || WATTR != 8'h07) e++;
        end
        chk("clr_all_seq_errors", e, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int e, w;
        tv = '{
            '{8'h42, 1'b1, 8'd1, 8'd0, 8'h42, 8'd2, 8'd0},
            '{8'h0D, 1'b0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd0},
            '{8'h43, 1'b1, 8'd0, 8'd0, 8'h43, 8'd1, 8'd0},
            '{8'h0A, 1'b0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd1},
            '{8'h44, 1'b1, 8'd0, 8'd1, 8'h44, 8'd1, 8'd1},
            '{8'h45, 1'b1, 8'd1, 8'd1, 8'h45, 8'd2, 8'd1},
            '{8'h46, 1'b1, 8'd2, 8'd1, 8'h46, 8'd3, 8'd1},
            '{8'h08, 1'b1, 8'd2, 8'd1, 8'h20, 8'd2, 8'd1},
            '{8'h01, 1'b0, 8'd0, 8'd0, 8'h00, 8'd2, 8'd1},
            '{8'h08, 1'b1, 8'd1, 8'd1, 8'h20, 8'd1, 8'd1},
            '{8'h08, 1'b1, 8'd0, 8'd1, 8'h20, 8'd0, 8'd1},
            '{8'h08, 1'b0, 8'd0, 8'd0, 8'h00, 8'd0, 8'd1},
            '{8'h7E, 1'b1, 8'd0, 8'd1, 8'h7E, 8'd1, 8'd1},
            '{8'h7F, 1'b0, 8'd0, 8'd0, 8'h00, 8'd1, 8'd1}
        };
        // Reset state
        repeat (3) @(negedge PIXCLK);
        chk("rst_we", WE, 0);
        chk("rst_wx", WX, 0);
        chk("rst_wy", WY, 0);
        chk("rst_wchar", WCHAR, 8'h20);
        chk("rst_wattr", WATTR, 8'h07);
        chk("rst_top", TOP_ROW, 0);
        chk("rst_cursor", {CURSOR_X, CURSOR_Y}, 0);
        chk("rst_ready", DIN_READY, 0);
        chk("rst_busy", BUSY, 1);
        // T1: release, abort mid-clear, then a full clear
        @(posedge PIXCLK); #2 _RST = 1'b1;
        run_clear_check(100);
        @(posedge PIXCLK); #2 _RST = 1'b0;
        #1 chk("midrst_we", WE, 0);
        chk("midrst_wx", WX, 0);
        @(posedge PIXCLK); #2 _RST = 1'b1;
        run_clear_check(2400);
        @(negedge PIXCLK);
        chk("clr_done_ready", DIN_READY, 1);
        chk("clr_done_we", WE, 0);
        // T2
        send(8'h41);
        chk("t2_we", WE, 1);
        chk("t2_wxy", {WX, WY}, 16'h0000);
        chk("t2_wchar", WCHAR, 8'h41);
        chk("t2_wattr", WATTR, 8'h07);
        chk("t2_ready_n1", DIN_READY, 0);
        @(negedge PIXCLK);
        chk("t2_ready_n2", DIN_READY, 1);
        chk("t2_cx", CURSOR_X, 1);
        // Table: printable, CR, LF, BS (incl. T5), ignored codes
        for (int i = 0; i < 14; i++) begin
            send(tv[i].din);
            chk($sformatf("tv%0d_we", i), WE, tv[i].we);
            if (tv[i].we) begin
                chk($sformatf("tv%0d_wx", i), WX, tv[i].wx);
                chk($sformatf("tv%0d_wy", i), WY, tv[i].wy);
                chk($sformatf("tv%0d_wchar", i), WCHAR, tv[i].wc);
            end
            @(negedge PIXCLK);
            chk($sformatf("tv%0d_ready", i), DIN_READY, 1);
            chk($sformatf("tv%0d_cursor", i), {CURSOR_X, CURSOR_Y}, {tv[i].cx, tv[i].cy});
        end
        // T3: line wrap
        clear_screen();
        for (int i = 0; i < 81; i++) begin
            send(8'h41);
            if (i == 79) chk("t3_w80", {WE, WX, WY}, {1'b1, 8'd79, 8'd0});
            if (i == 80) chk("t3_w81", {WE, WX, WY}, {1'b1, 8'd0, 8'd1});
        end
        @(negedge PIXCLK);
        chk("t3_cursor", {CURSOR_X, CURSOR_Y}, {8'd1, 8'd1});
        // T4: scroll
        clear_screen();
        repeat (29) send(8'h0A);
        wait_ready();
        chk("t4_pre_cy", CURSOR_Y, 29);
        chk("t4_pre_top", TOP_ROW, 0);
        send(8'h0A);
        chk("t4_lf_we", WE, 0);
        e = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge PIXCLK);
            if (!WE || WX != 8'(k) || WY != 8'd0 || WCHAR != 8'h20 || WATTR != 8'h07) e++;
        end
        chk("t4_clr_line_errors", e, 0);
        @(negedge PIXCLK);
        chk("t4_ready_after", DIN_READY, 1);
        chk("t4_we_after", WE, 0);
        chk("t4_top", TOP_ROW, 1);
        chk("t4_cursor", {CURSOR_X, CURSOR_Y}, {8'd0, 8'd29});
        send(8'h42);
        chk("t4_b_write", {WE, WX, WY, WCHAR}, {1'b1, 8'd0, 8'd0, 8'h42});
        // TOP_ROW wraps 29 -> 0 after 29 more scrolls
        repeat (29) send(8'h0A);
        wait_ready();
        chk("top_wrap", TOP_ROW, 0);
        send(8'h43);
        chk("top_wrap_write", {WE, WX, WY}, {1'b1, 8'd0, 8'd29});
        // T6: attribute escape
        clear_screen();
        w = 0;
        send(8'h1B);
        w += int'(WE);
        send(8'h1E);
        w += int'(WE);
        chk("t6_esc_no_write", w, 0);
        send(8'h41);
        chk("t6_we", WE, 1);
        chk("t6_wchar", WCHAR, 8'h41);
        chk("t6_wattr", WATTR, EA);
        clear_screen();
        send(8'h41);
        chk("t6_attr_after_ff", WATTR, EA);
        @(negedge PIXCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
